// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Define MDU_EARLY_OUT_EN to let multiplies finish early once the multiplier is exhausted.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [1:0]         op;
    logic [WIDTH-1:0]   ra, rb;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] m, acc;
    logic [WIDTH-1:0]   y;
    logic [CW-1:0]      cnt;

    logic             sgn, sa, sb;
    logic [WIDTH-1:0] aa, ab;
    logic [WIDTH:0]   trial, sub;
    logic             ge;
    logic             run_last;

    assign sgn = ~op[0];
    assign sa  = sgn & ra[WIDTH-1];
    assign sb  = sgn & rb[WIDTH-1];
    assign aa  = sa ? -ra : ra;
    assign ab  = sb ? -rb : rb;

    // Restoring divide step: remainder (in acc) shifts in the next dividend bit.
    assign trial = {acc[WIDTH-1:0], y[WIDTH-1]};
    assign sub   = trial - {1'b0, m[WIDTH-1:0]};
    assign ge    = ~sub[WIDTH];

`ifdef MDU_EARLY_OUT_EN
    assign run_last = (cnt == '0) || (!op[1] && (y[WIDTH-1:1] == '0));
`else
    assign run_last = (cnt == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            op          <= '0;
            ra          <= '0;
            rb          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            m           <= '0;
            acc         <= '0;
            y           <= '0;
            cnt         <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        op    <= funct;
                        busy  <= 1'b1;
                        state <= PREP;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                PREP: begin
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    acc   <= '0;
                    cnt   <= CW'(WIDTH - 1);
                    if (op[1] && rb == '0) begin
                        hi          <= ra;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (op[1]) begin
                        m     <= {{WIDTH{1'b0}}, ab};
                        y     <= aa;
                        state <= RUN;
                    end else begin
                        m     <= {{WIDTH{1'b0}}, aa};
                        y     <= ab;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (op[1]) begin
                        acc <= {{WIDTH{1'b0}},
                                ge ? sub[WIDTH-1:0] : trial[WIDTH-1:0]};
                        y   <= {y[WIDTH-2:0], ge};
                    end else begin
                        if (y[0]) acc <= acc + m;
                        m <= m << 1;
                        y <= y >> 1;
                    end
                    if (run_last) state <= FIX;
                end
                FIX: begin
                    if (op[1]) begin
                        lo <= neg_q ? -y : y;
                        hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
